// File: rtl/ray_dispatcher.sv
// Primary-ray generator: walks the screen in raster order, emits one ray per pixel into
// the core input FIFO under back-pressure, then waits for the core to finish the frame.

module ray_dir_lane #(
   parameter int FIX_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             adv_x,
   input  logic             adv_row,
   input  logic [FIX_W-1:0] corner,
   input  logic [FIX_W-1:0] du,
   input  logic [FIX_W-1:0] dv,
   output logic [FIX_W-1:0] dir
);
   logic [FIX_W-1:0] row_dir, du_q, dv_q;

   // The row base is kept separately so a row wrap steps from it rather than
   // unwinding WIDTH-1 du steps; this is what keeps the row wrap bubble-free.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dir     <= '0;
         row_dir <= '0;
         du_q    <= '0;
         dv_q    <= '0;
      end else if (load) begin
         dir     <= corner;
         row_dir <= corner;
         du_q    <= du;
         dv_q    <= dv;
      end else if (adv_x) begin
         dir <= dir + du_q;
      end else if (adv_row) begin
         row_dir <= row_dir + dv_q;
         dir     <= row_dir + dv_q;
      end
   end
endmodule

module ray_dispatcher #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int FIX_W  = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [2:0][FIX_W-1:0] cam_origin,
   input  logic [2:0][FIX_W-1:0] cam_corner,
   input  logic [2:0][FIX_W-1:0] cam_du,
   input  logic [2:0][FIX_W-1:0] cam_dv,
   input  logic                  fifo_full,
   input  logic [31:0]           pixel_counter,
   output logic                  add_input,
   output logic [15:0]           ray_x,
   output logic [15:0]           ray_y,
   output logic [2:0][FIX_W-1:0] ray_orig,
   output logic [2:0][FIX_W-1:0] ray_dir,
   output logic                  reset_pixel_counter,
   output logic                  busy,
   output logic                  frame_done
);
   localparam logic [15:0] XMAX = 16'(WIDTH - 1);
   localparam logic [15:0] YMAX = 16'(HEIGHT - 1);
   localparam logic [31:0] NPIX = 32'(WIDTH * HEIGHT);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [15:0]             x_q, y_q;
   logic [2:0][FIX_W-1:0]   orig_q;
   logic                    load, adv_x, adv_row;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt           = state;
      add_input           = 1'b0;
      reset_pixel_counter = 1'b0;
      load                = 1'b0;
      adv_x               = 1'b0;
      adv_row             = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load                = 1'b1;
               reset_pixel_counter = 1'b1;
               state_nxt           = ISSUE;
            end
         end
         ISSUE: begin
            add_input = !fifo_full;
            if (add_input) begin
               if (x_q < XMAX)      adv_x     = 1'b1;
               else if (y_q < YMAX) adv_row   = 1'b1;
               else                 state_nxt = DRAIN;
            end
         end
         // Bounced rays recirculate inside the core and never bump the counter,
         // so reaching the frame size means every primary ray has retired.
         DRAIN: begin
            if (pixel_counter >= NPIX) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_q    <= '0;
         y_q    <= '0;
         orig_q <= '0;
      end else if (load) begin
         x_q    <= '0;
         y_q    <= '0;
         orig_q <= cam_origin;
      end else if (adv_x) begin
         x_q <= x_q + 16'd1;
      end else if (adv_row) begin
         x_q <= '0;
         y_q <= y_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) frame_done <= 1'b0;
      else         frame_done <= (state == DONE);
   end

   for (genvar c = 0; c < 3; c++) begin : g_lane
      ray_dir_lane #(.FIX_W(FIX_W)) u_lane (
         .clk    (clk),
         .resetn (resetn),
         .load   (load),
         .adv_x  (adv_x),
         .adv_row(adv_row),
         .corner (cam_corner[c]),
         .du     (cam_du[c]),
         .dv     (cam_dv[c]),
         .dir    (ray_dir[c])
      );
   end

   assign ray_x    = x_q;
   assign ray_y    = y_q;
   assign ray_orig = orig_q;
   assign busy     = (state != IDLE);
endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher on a 4x2 screen: a ray-index model (dir = corner + x*du + y*dv)
// checked every cycle, plus directed frames with literal expectations.

module tb_ray_dispatcher;
   localparam int W    = 4;
   localparam int H    = 2;
   localparam int NPIX = W * H;

   logic              clk = 1'b0;
   logic              resetn;
   logic              start;
   logic [2:0][31:0]  cam_origin, cam_corner, cam_du, cam_dv;
   logic              fifo_full;
   logic [31:0]       pixel_counter;
   logic              add_input;
   logic [15:0]       ray_x, ray_y;
   logic [2:0][31:0]  ray_orig, ray_dir;
   logic              reset_pixel_counter, busy, frame_done;

   ray_dispatcher #(.WIDTH(W), .HEIGHT(H), .FIX_W(32)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .cam_origin(cam_origin), .cam_corner(cam_corner), .cam_du(cam_du), .cam_dv(cam_dv),
      .fifo_full(fifo_full), .pixel_counter(pixel_counter),
      .add_input(add_input), .ray_x(ray_x), .ray_y(ray_y),
      .ray_orig(ray_orig), .ray_dir(ray_dir),
      .reset_pixel_counter(reset_pixel_counter), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: frame phase (0 idle, 1 issuing, 2 waiting on core, 3 done) and ray index.
   int               m_phase = 0;
   int               m_k = 0;
   logic             m_fd = 1'b0;
   logic [2:0][31:0] m_org, m_cor, m_du, m_dv;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_phase = 0; m_k = 0; m_fd = 1'b0;
      end else begin
         m_fd = (m_phase == 3);
         case (m_phase)
            0: if (start) begin
                  m_org = cam_origin; m_cor = cam_corner; m_du = cam_du; m_dv = cam_dv;
                  m_k = 0; m_phase = 1;
               end
            1: if (!fifo_full) begin
                  m_k++;
                  if (m_k == NPIX) m_phase = 2;
               end
            2: if (pixel_counter >= NPIX) m_phase = 3;
            default: m_phase = 0;
         endcase
      end
   end

   logic [15:0]      qx[$], qy[$];
   logic [2:0][31:0] qd[$];

   always @(negedge clk) begin
      int xx, yy;
      logic [2:0][31:0] ed;
      chk("busy", busy, m_phase != 0);
      chk("add_input", add_input, (m_phase == 1) && !fifo_full);
      chk("reset_pixel_counter", reset_pixel_counter, (m_phase == 0) && start);
      chk("frame_done", frame_done, m_fd);
      if (m_phase == 1 && !fifo_full && add_input) begin
         xx = m_k % W;
         yy = m_k / W;
         for (int c = 0; c < 3; c++) ed[c] = m_cor[c] + 32'(xx) * m_du[c] + 32'(yy) * m_dv[c];
         chk("ray_x", ray_x, 16'(xx));
         chk("ray_y", ray_y, 16'(yy));
         chk("ray_dir", ray_dir, ed);
         chk("ray_orig", ray_orig, m_org);
         qx.push_back(ray_x); qy.push_back(ray_y); qd.push_back(ray_dir);
      end
   end

   // Pulse start, then issue until n_stop rays are accepted; camera inputs are scrambled
   // after the latch cycle to show the frame ignores them.
   task automatic run_frame(input logic [63:0] stall, input int restart_at, input int n_stop,
                            output int cyc);
      int nacc;
      logic [2:0][31:0] saved;
      qx.delete(); qy.delete(); qd.delete();
      @(posedge clk); #1 start = 1'b1;
      @(negedge clk);
      chk("rpc_on_start", reset_pixel_counter, 1'b1);
      @(posedge clk); #1 start = 1'b0;
      saved = cam_corner;
      cam_corner = ~cam_corner;
      cyc = 0; nacc = 0;
      while (nacc < n_stop && cyc < 60) begin
         cyc++;
         fifo_full = stall[cyc];
         start     = (cyc == restart_at);
         @(negedge clk);
         if (add_input) nacc++;
         @(posedge clk); #1;
      end
      start = 1'b0; fifo_full = 1'b0;
      cam_corner = saved;
      chk("rays_accepted", 32'(nacc), 32'(n_stop));
   endtask

   task automatic finish_frame();
      int n;
      logic seen;
      pixel_counter = NPIX;
      seen = 1'b0;
      for (n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = frame_done;
         @(posedge clk); #1;
      end
      chk("frame_done_seen", seen, 1'b1);
      pixel_counter = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1);
   end

   initial begin
      int cyc;
      resetn = 1'b0; start = 1'b0; fifo_full = 1'b0; pixel_counter = 0;
      cam_origin = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
      cam_corner = {32'hFFFF_0000, 32'h0, 32'h0};
      cam_du     = {32'h0, 32'h0, 32'h0000_4000};
      cam_dv     = {32'h0, 32'h0000_8000, 32'h0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_add_input", add_input, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_ray_dir", ray_dir, 96'h0);
      chk("rst_ray_xy", {ray_x, ray_y}, 32'h0);
      @(posedge clk); #1 resetn = 1'b1;

      // Frame A: no back-pressure, then a drain that holds at 7 before completing.
      run_frame(64'h0, -1, NPIX, cyc);
      chk("A_issue_cycles", 32'(cyc), 32'd8);
      for (int i = 0; i < NPIX && i < qx.size(); i++) begin
         chk("A_x_order", qx[i], 16'(i % W));
         chk("A_y_order", qy[i], 16'(i / W));
      end
      if (qd.size() > 4) chk("A_ray5_dir", qd[4], {32'hFFFF_0000, 32'h0000_8000, 32'h0});
      else chk("A_ray5_present", 32'(qd.size()), 32'd8);
      pixel_counter = 7;
      repeat (10) begin
         @(negedge clk);
         chk("drain_busy", busy, 1'b1);
         chk("drain_no_done", frame_done, 1'b0);
         @(posedge clk); #1;
      end
      pixel_counter = 8;
      @(negedge clk);  chk("done_t0", {busy, frame_done}, 2'b10);
      @(posedge clk); #1;
      @(negedge clk);  chk("done_t1", {busy, frame_done}, 2'b10);
      @(posedge clk); #1;
      @(negedge clk);  chk("done_t2", {busy, frame_done}, 2'b01);
      @(posedge clk); #1;
      @(negedge clk);  chk("done_t3", {busy, frame_done}, 2'b00);
      @(posedge clk); #1 pixel_counter = 0;

      // Frame B: stalls on cycles 2-4, start re-pulsed mid-issue.
      run_frame(64'h1C, 5, NPIX, cyc);
      chk("B_issue_cycles", 32'(cyc), 32'd11);
      if (qx.size() == NPIX) begin
         chk("B_first_xy", {qx[0], qy[0]}, 32'h0);
         chk("B_last_xy", {qx[7], qy[7]}, {16'd3, 16'd1});
      end
      finish_frame();

      // Reset mid-row at (2,1), then a clean frame.
      run_frame(64'h0, -1, 6, cyc);
      @(negedge clk);
      chk("pre_rst_pos", {add_input, ray_x, ray_y}, {1'b1, 16'd2, 16'd1});
      #1 resetn = 1'b0;
      #1;
      chk("midrst_outputs", {busy, add_input, frame_done}, 3'b000);
      @(posedge clk); #1 resetn = 1'b1;
      run_frame(64'h0, -1, NPIX, cyc);
      chk("postrst_cycles", 32'(cyc), 32'd8);
      if (qx.size() > 0) chk("postrst_first_xy", {qx[0], qy[0]}, 32'h0);
      finish_frame();

      // Wraparound: no saturation on direction adds.
      cam_corner = {32'h0, 32'h0, 32'h0000_0001};
      cam_du     = {32'h0, 32'h0, 32'h7FFF_FFFF};
      run_frame(64'h0, -1, NPIX, cyc);
      if (qd.size() > 2) begin
         chk("wrap_ray1_dirx", qd[1][0], 32'h8000_0000);
         chk("wrap_ray2_dirx", qd[2][0], 32'hFFFF_FFFF);
      end else chk("wrap_rays_present", 32'(qd.size()), 32'd8);
      finish_frame();

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
